// File: rtl/shift_pipe.sv
// ARM operand-2 barrel shifter: registered decode followed by
// STAGES rotate stages; every shift is a rotate plus keep/fill mask.
module shift_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       shift_type,
  input  logic [7:0]       shift_num,
  input  logic             reg_shift,
  input  logic             not_shift,
  input  logic [WIDTH-1:0] x,
  input  logic             carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             c
);

  localparam int L = $clog2(WIDTH);
  localparam int D = STAGES + 1;
  localparam logic [7:0] WN = 8'(WIDTH);
  localparam logic [WIDTH-1:0] ONES = '1;

  typedef enum logic [1:0] {
    T_LSL = 2'b00,
    T_LSR = 2'b01,
    T_ASR = 2'b10,
    T_ROR = 2'b11
  } st_e;

  typedef struct packed {
    logic [WIDTH-1:0] dat;
    logic [L-1:0]     rot;
    logic [WIDTH-1:0] keep;
    logic             fill;
    logic             c;
  } ent_t;

  logic [7:0]   w_n;
  logic [L-1:0] w_m;
  logic [L-1:0] w_neg;
  logic [L-1:0] w_mm1;
  logic         w_msb;
  ent_t         w_dec;
  ent_t         w_si [D];
  ent_t         w_so [D];
  logic [D-1:0] w_vin;
  logic         w_adv;

  ent_t         r_ent [D];
  logic [D-1:0] r_vld;

  assign w_n   = reg_shift ? shift_num : 8'(shift_num[L-1:0]);
  assign w_m   = w_n[L-1:0];
  assign w_neg = -w_m;
  assign w_mm1 = w_m - L'(1);
  assign w_msb = x[WIDTH-1];

  always_comb begin
    w_dec      = '0;
    w_dec.dat  = x;
    w_dec.keep = ONES;
    w_dec.c    = carry;
    if (not_shift) begin
      w_dec.c = carry;
    end else if (!reg_shift && w_m == '0 &&
                 st_e'(shift_type) != T_LSL) begin
      // immediate #0 encodes LSR/ASR #WIDTH and RRX
      unique case (st_e'(shift_type))
        T_LSR: begin
          w_dec.keep = '0;
          w_dec.c    = w_msb;
        end
        T_ASR: begin
          w_dec.keep = '0;
          w_dec.fill = w_msb;
          w_dec.c    = w_msb;
        end
        default: begin
          w_dec.rot  = L'(1);
          w_dec.keep = ONES >> 1;
          w_dec.fill = carry;
          w_dec.c    = x[0];
        end
      endcase
    end else if (w_n != '0) begin
      unique case (st_e'(shift_type))
        T_LSL: begin
          if (w_n < WN) begin
            w_dec.rot  = w_neg;
            w_dec.keep = ONES << w_m;
            w_dec.c    = x[w_neg];
          end else begin
            w_dec.keep = '0;
            w_dec.c    = (w_n == WN) ? x[0] : 1'b0;
          end
        end
        T_LSR: begin
          if (w_n < WN) begin
            w_dec.rot  = w_m;
            w_dec.keep = ONES >> w_m;
            w_dec.c    = x[w_mm1];
          end else begin
            w_dec.keep = '0;
            w_dec.c    = (w_n == WN) ? w_msb : 1'b0;
          end
        end
        T_ASR: begin
          w_dec.fill = w_msb;
          if (w_n < WN) begin
            w_dec.rot  = w_m;
            w_dec.keep = ONES >> w_m;
            w_dec.c    = x[w_mm1];
          end else begin
            w_dec.keep = '0;
            w_dec.c    = w_msb;
          end
        end
        default: begin
          w_dec.rot = w_m;
          w_dec.c   = (w_m == '0) ? w_msb : x[w_mm1];
        end
      endcase
    end
  end

  always_comb begin
    w_si[0]  = w_dec;
    w_vin[0] = in_valid;
    for (int s = 1; s < D; s++) begin
      w_si[s]  = r_ent[s-1];
      w_vin[s] = r_vld[s-1];
    end
  end

  // rotate layer j lives in stage 1 + j*STAGES/L; mask in the last
  always_comb begin
    ent_t v;
    v = '0;
    for (int s = 0; s < D; s++) begin
      v = w_si[s];
      for (int j = 0; j < L; j++) begin
        if ((1 + (j * STAGES) / L) == s && v.rot[j])
          v.dat = (v.dat >> (2 ** j)) |
                  (v.dat << (WIDTH - 2 ** j));
      end
      if (s == D - 1)
        v.dat = (v.dat & v.keep) |
                ({WIDTH{v.fill}} & ~v.keep);
      w_so[s] = v;
    end
  end

  assign w_adv     = !r_vld[D-1] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[D-1];
  assign y         = r_ent[D-1].dat;
  assign c         = r_ent[D-1].c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      for (int s = 0; s < D; s++) r_ent[s] <= '0;
    end else begin
      if (flush) r_vld <= '0;
      else if (w_adv) r_vld <= w_vin;
      if (w_adv)
        for (int s = 0; s < D; s++) r_ent[s] <= w_so[s];
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe at WIDTH=32, STAGES=2.
// Each task drives its scenario and checks results inline.
module tb_shift_pipe;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  shift_type;
  logic [7:0]  shift_num;
  logic        reg_shift;
  logic        not_shift;
  logic [31:0] x;
  logic        carry;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        c;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    string       nm;
    logic [1:0]  t;
    logic [7:0]  n;
    logic        rs;
    logic [31:0] xv;
    logic        cy;
    logic [31:0] ey;
    logic        ec;
  } vec_t;

  shift_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .shift_type(shift_type), .shift_num(shift_num),
    .reg_shift(reg_shift), .not_shift(not_shift),
    .x(x), .carry(carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .c(c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input vec_t v, input logic ns);
    shift_type = v.t;
    shift_num  = v.n;
    reg_shift  = v.rs;
    not_shift  = ns;
    x          = v.xv;
    carry      = v.cy;
  endtask

  task automatic run_one(input vec_t v, input logic ns,
                         output logic [31:0] oy,
                         output logic oc, output int lat);
    drive(v, ns);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    oy = y;
    oc = c;
    @(posedge clk); #1;
  endtask

  task automatic run_table(input vec_t tbl[$]);
    logic [31:0] gy;
    logic        gc;
    int          lat;
    foreach (tbl[i]) begin
      run_one(tbl[i], 1'b0, gy, gc, lat);
      nvec++;
      if (gy !== tbl[i].ey || gc !== tbl[i].ec || lat != 2) begin
        nerr++;
        $display("FAIL %s: got y=%h c=%b lat=%0d, want y=%h c=%b lat=2",
                 tbl[i].nm, gy, gc, lat, tbl[i].ey, tbl[i].ec);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++; $display("FAIL rst_valid: got %b want 0", out_valid);
    end
    nvec++;
    if (y !== 32'h0) begin
      nerr++; $display("FAIL rst_y: got %h want 0", y);
    end
    nvec++;
    if (c !== 1'b0) begin
      nerr++; $display("FAIL rst_c: got %b want 0", c);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL rst_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_latency();
    vec_t v;
    logic [31:0] gy;
    logic gc;
    int lat;
    v = '{"lsl1", 2'b00, 8'd1, 1'b1, 32'hFFFFFFFF, 1'b0,
          32'hFFFFFFFE, 1'b1};
    run_one(v, 1'b0, gy, gc, lat);
    nvec++;
    if (lat != 2) begin
      nerr++; $display("FAIL lat: got %0d want 2", lat);
    end
    nvec++;
    if (gy !== 32'hFFFFFFFE) begin
      nerr++; $display("FAIL lat_y: got %h want FFFFFFFE", gy);
    end
    nvec++;
    if (gc !== 1'b1) begin
      nerr++; $display("FAIL lat_c: got %b want 1", gc);
    end
  endtask

  task automatic test_large();
    vec_t tbl[$];
    tbl.push_back('{"lsl32", 2'b00, 8'd32, 1'b1, 32'h1, 1'b0, 32'h0, 1'b1});
    tbl.push_back('{"lsl33", 2'b00, 8'd33, 1'b1, 32'h1, 1'b1, 32'h0, 1'b0});
    tbl.push_back('{"lsr32", 2'b01, 8'd32, 1'b1, 32'h80000000, 1'b0, 32'h0, 1'b1});
    tbl.push_back('{"asr200", 2'b10, 8'd200, 1'b1, 32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b1});
    tbl.push_back('{"ror64", 2'b11, 8'd64, 1'b1, 32'h80000001, 1'b0, 32'h80000001, 1'b1});
    tbl.push_back('{"asr4", 2'b10, 8'd4, 1'b1, 32'h80000010, 1'b1, 32'hF8000001, 1'b0});
    tbl.push_back('{"ror8", 2'b11, 8'd8, 1'b1, 32'h12345678, 1'b1, 32'h78123456, 1'b0});
    tbl.push_back('{"lsr4", 2'b01, 8'd4, 1'b1, 32'h0000001F, 1'b0, 32'h1, 1'b1});
    tbl.push_back('{"lsl31", 2'b00, 8'd31, 1'b1, 32'h3, 1'b0, 32'h80000000, 1'b1});
    run_table(tbl);
  endtask

  task automatic test_imm();
    vec_t tbl[$];
    tbl.push_back('{"lsr_i0", 2'b01, 8'd0, 1'b0, 32'h80000000, 1'b0, 32'h0, 1'b1});
    tbl.push_back('{"rrx", 2'b11, 8'd0, 1'b0, 32'h1, 1'b1, 32'h80000000, 1'b1});
    tbl.push_back('{"lsl_i0", 2'b00, 8'd0, 1'b0, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b1});
    tbl.push_back('{"asr_i0", 2'b10, 8'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 32'h0, 1'b0});
    tbl.push_back('{"lsl_i33", 2'b00, 8'h21, 1'b0, 32'h1, 1'b1, 32'h2, 1'b0});
    run_table(tbl);
  endtask

  task automatic test_back_to_back();
    vec_t v[4];
    int acc = 0;
    int got = 0;
    int hold = 0;
    int extra = 0;
    bit seen = 0;
    v[0] = '{"bp0", 2'b00, 8'd4, 1'b1, 32'hF, 1'b0, 32'hF0, 1'b0};
    v[1] = '{"bp1", 2'b01, 8'd1, 1'b1, 32'h3, 1'b0, 32'h1, 1'b1};
    v[2] = '{"bp2", 2'b10, 8'd31, 1'b1, 32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b0};
    v[3] = '{"bp3", 2'b11, 8'd4, 1'b0, 32'hF, 1'b0, 32'hF0000000, 1'b1};
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      if (out_valid && !seen) begin
        seen = 1;
        hold = 3;
      end
      if (hold > 0) begin
        out_ready = 1'b0;
        hold--;
        nvec++;
        if (!out_valid || y !== v[0].ey || c !== v[0].ec) begin
          nerr++;
          $display("FAIL hold_out: got v=%b y=%h c=%b want v=1 y=%h c=%b",
                   out_valid, y, c, v[0].ey, v[0].ec);
        end
      end else begin
        out_ready = 1'b1;
      end
      if (acc < 4) begin
        drive(v[acc], 1'b0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready) begin
        nvec++;
        if (in_ready !== 1'b0) begin
          nerr++; $display("FAIL hold_ready: got %b want 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        nvec++;
        if (y !== v[got].ey || c !== v[got].ec) begin
          nerr++;
          $display("FAIL %s: got y=%h c=%b want y=%h c=%b",
                   v[got].nm, y, c, v[got].ey, v[got].ec);
        end
        got++;
      end
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      if (out_valid) extra++;
      @(posedge clk); #1;
    end
    nvec++;
    if (got != 4 || acc != 4 || extra != 0) begin
      nerr++;
      $display("FAIL bp_count: got res=%0d acc=%0d extra=%0d want 4 4 0",
               got, acc, extra);
    end
  endtask

  task automatic test_flush();
    vec_t v;
    logic [31:0] gy;
    logic gc;
    int lat;
    int seen = 0;
    out_ready = 1'b1;
    v = '{"fa", 2'b00, 8'd1, 1'b1, 32'h1, 1'b0, 32'h2, 1'b0};
    drive(v, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    x = 32'h10;
    @(posedge clk); #1;
    flush = 1'b1;
    x = 32'h100;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++; $display("FAIL flush_valid: got %b want 0", out_valid);
    end
    repeat (6) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    nvec++;
    if (seen != 0) begin
      nerr++; $display("FAIL flush_leak: got %0d results want 0", seen);
    end
    v = '{"bypass", 2'b11, 8'd31, 1'b1, 32'h7FFFFFFF, 1'b0,
          32'h7FFFFFFF, 1'b0};
    run_one(v, 1'b1, gy, gc, lat);
    not_shift = 1'b0;
    nvec++;
    if (gy !== 32'h7FFFFFFF || gc !== 1'b0 || lat != 2) begin
      nerr++;
      $display("FAIL bypass: got y=%h c=%b lat=%0d want y=7fffffff c=0 lat=2",
               gy, gc, lat);
    end
  endtask

  task automatic test_async_reset();
    vec_t v;
    int seen = 0;
    out_ready = 1'b0;
    v = '{"ar", 2'b01, 8'd8, 1'b1, 32'hFF00FF00, 1'b0, 32'h00FF00FF, 1'b0};
    drive(v, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    x = 32'h12345678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    nvec++;
    if (out_valid !== 1'b1 || y !== 32'h00FF00FF) begin
      nerr++;
      $display("FAIL ar_stall: got v=%b y=%h want v=1 y=00ff00ff",
               out_valid, y);
    end
    #2;
    reset_n = 1'b0;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || y !== 32'h0) begin
      nerr++;
      $display("FAIL ar_drop: got v=%b y=%h want v=0 y=0", out_valid, y);
    end
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    repeat (6) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    nvec++;
    if (seen != 0) begin
      nerr++; $display("FAIL ar_stale: got %0d results want 0", seen);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    shift_type = 2'b00;
    shift_num  = 8'd0;
    reg_shift  = 1'b0;
    not_shift  = 1'b0;
    x          = 32'h0;
    carry      = 1'b0;
    test_reset();
    test_latency();
    test_large();
    test_imm();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined barrel shifter producing the ARM operand-2 value and shifter carry-out for the data-processing path. It generalises the single-cycle shifter in three ways: configurable data width, a configurable number of register stages, and full ARM semantics for register-specified amounts of WIDTH or more. It has a valid/ready handshake on both sides and a synchronous flush. It sits between register read and the ALU in the pipelined core.

## Interface

Parameters:
- WIDTH, 32: data width. Must be a power of two, 8..128.
- STAGES, 2: pipeline register stages, 1..$clog2(WIDTH). Latency equals STAGES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; clears all in-flight entries.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- shift_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR/RRX.
- shift_num  in  8  shift amount.
- reg_shift  in  1  1 = amount comes from a register (all 8 bits used); 0 = immediate (low $clog2(WIDTH) bits used).
- not_shift  in  1  bypass: y = x, c = carry.
- x  in  WIDTH  operand.
- carry  in  1  current C flag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result when out_valid && out_ready.
- y  out  WIDTH  shifted result.
- c  out  1  shifter carry-out.

## Operation

- Immediate mode (reg_shift = 0), n = shift_num[$clog2(WIDTH)-1:0]:
  - LSL with n = 0: y = x, c = carry.
  - LSR or ASR with n = 0: encodes a shift of WIDTH.
  - ROR with n = 0: RRX, y = {carry, x[W-1:1]}, c = x[0].
  - Otherwise n takes the register-mode rules below.
- Register mode (reg_shift = 1), n = shift_num (0..255), W = WIDTH:
  - n = 0, any type: y = x, c = carry.
  - LSL:
    - n < W: y = x << n, c = x[W-n].
    - n = W: y = 0, c = x[0].
    - n > W: y = 0, c = 0.
  - LSR:
    - n < W: y = x >> n, c = x[n-1].
    - n = W: y = 0, c = x[W-1].
    - n > W: y = 0, c = 0.
  - ASR:
    - n < W: arithmetic shift, c = x[n-1].
    - n >= W: y = {W{x[W-1]}}, c = x[W-1].
  - ROR: m = n mod W.
    - m = 0: y = x, c = x[W-1].
    - Otherwise rotate right by m, c = x[m-1].
- not_shift = 1 overrides everything: y = x, c = carry.
- The stage split is implementer's choice (decode, then log2 shift layers distributed over STAGES). The result must be independent of STAGES.

## Timing

- Reset (reset_n low, async):
  - All stage valid bits are 0; out_valid = 0.
  - y = 0 and c = 0.
  - in_ready = 1 one cycle after reset deasserts, and combinationally whenever the pipe can advance.
- Pipeline:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - On advance, every stage shifts forward one entry.
  - Empty slots (bubbles) travel as invalid entries and are not compressed.
- Latency: a request accepted at edge k presents out_valid with its result after edge k+STAGES, provided there is no stall.
- Throughput: one result per cycle with out_ready held at 1.
- Stall: while out_valid && !out_ready, y, c and out_valid are held stable, in_ready = 0, and no input is consumed.
- Flush:
  - All valid bits clear at the next edge, including the output stage, so out_valid = 0 in the following cycle.
  - A request presented in the same cycle as flush is dropped.
  - Data registers may keep stale values.
- Reset asserted mid-operation discards all entries immediately.
- Result ordering is strict FIFO.

## Test plan

All scenarios use WIDTH = 32 and STAGES = 2.

1. Reset and latency:
   - Release reset; out_valid = 0, y = 0, c = 0.
   - Issue LSL, reg mode, n = 1, x = FFFFFFFF, out_ready = 1.
   - Expect y = FFFFFFFE, c = 1 with out_valid exactly 2 cycles after acceptance.
2. Large register amounts:
   - LSL n = 32, x = 1 -> y = 0, c = 1.
   - LSL n = 33 -> y = 0, c = 0.
   - LSR n = 32, x = 80000000 -> y = 0, c = 1.
   - ASR n = 200, x = 80000000 -> y = FFFFFFFF, c = 1.
   - ROR n = 64, x = 80000001 -> y = 80000001, c = 1.
3. Immediate specials:
   - LSR #0, x = 80000000 -> y = 0, c = 1.
   - ROR #0 with carry = 1, x = 1 -> y = 80000000, c = 1.
   - LSL #0 with carry = 1 -> y = x, c = 1.
4. Back-pressure:
   - Stream 4 back-to-back requests; hold out_ready = 0 for 3 cycles after the first result.
   - Expect y/c stable, in_ready = 0 during the hold.
   - All 4 results arrive in order with no loss or duplication.
5. Flush and bypass:
   - Flush with 2 entries in flight -> out_valid = 0 next cycle and neither result ever appears.
   - Then issue not_shift = 1, ROR n = 31, x = 7FFFFFFF, carry = 0 -> y = 7FFFFFFF, c = 0.
6. Async reset during a stall: assert reset_n low mid-stream -> out_valid drops without waiting for clk, and no stale result is emitted after release.
